alu_op_sequencer: RTL

//   Parametrised multi-cycle ALU sequencer for the RISC core's execute stage.

---
 rtl/alu_op_sequencer.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/alu_op_sequencer.sv
// Multi-cycle ALU sequencer: single-cycle ADD/SUB/AND/OR, iterative MUL/SHL/SHR,
// valid/ready on both sides. Optional flag outputs enabled by defining ALU_FLAGS_EN.
module alu_op_sequencer #(
    parameter int DATA_W = 16,
    parameter int OP_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic [1:0]        alu_ctrl,
`ifdef ALU_FLAGS_EN
    output logic              flag_z,
    output logic              flag_n,
    output logic              flag_c,
`endif
    output logic              illegal
);

    localparam int SH_W  = $clog2(DATA_W);
    localparam int CNT_W = $clog2(DATA_W + 1);

    localparam logic [OP_W-1:0] OP_ADD = OP_W'(0);
    localparam logic [OP_W-1:0] OP_SUB = OP_W'(1);
    localparam logic [OP_W-1:0] OP_AND = OP_W'(2);
    localparam logic [OP_W-1:0] OP_OR  = OP_W'(3);
    localparam logic [OP_W-1:0] OP_MUL = OP_W'(4);
    localparam logic [OP_W-1:0] OP_SHL = OP_W'(5);
    localparam logic [OP_W-1:0] OP_SHR = OP_W'(6);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_e;
    typedef enum logic [1:0] {IT_MUL, IT_SHL, IT_SHR} iter_e;

    state_e            state_q;
    iter_e             iter_q;
    logic [DATA_W-1:0] acc_q;
    logic [DATA_W-1:0] mcand_q;
    logic [DATA_W-1:0] mplier_q;
    logic [DATA_W-1:0] result_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [1:0]        ctrl_q;
    logic              illegal_q;

    logic              accept;
    logic              is_shift;
    logic              is_illegal;
    logic [SH_W-1:0]   shamt;
    logic [DATA_W-1:0] imm_res;
    logic [DATA_W-1:0] step_acc;
    logic [DATA_W-1:0] fin_res;
    logic              fin_load;

    // fin_load marks the single cycle in which the final result is known and DONE is entered.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        imm_res    = '0;
        step_acc   = acc_q;
        fin_load   = 1'b0;
        fin_res    = '0;
        accept     = in_valid && (state_q == S_IDLE);
        shamt      = b[SH_W-1:0];
        is_shift   = (op == OP_SHL) || (op == OP_SHR);
        is_illegal = (op > OP_SHR);

        case (op)
            OP_ADD:  imm_res = a + b;
            OP_SUB:  imm_res = a - b;
            OP_AND:  imm_res = a & b;
            OP_OR:   imm_res = a | b;
            default: imm_res = '0;
        endcase

        case (iter_q)
            IT_SHL:  step_acc = acc_q << 1;
            IT_SHR:  step_acc = acc_q >> 1;
            default: step_acc = mplier_q[0] ? acc_q + mcand_q : acc_q;
        endcase

        if (accept && (op != OP_MUL) && !(is_shift && (shamt != '0))) begin
            fin_load = 1'b1;
            fin_res  = is_shift ? a : imm_res;
        end else if ((state_q == S_EXEC) && (cnt_q == CNT_W'(1))) begin
            fin_load = 1'b1;
            fin_res  = step_acc;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            iter_q    <= IT_MUL;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            result_q  <= '0;
            cnt_q     <= '0;
            ctrl_q    <= 2'b00;
            illegal_q <= 1'b0;
        end else begin
            if (fin_load) result_q <= fin_res;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        illegal_q <= is_illegal;
                        acc_q     <= (op == OP_MUL) ? '0 : a;
                        mcand_q   <= a;
                        mplier_q  <= b;
                        if (op == OP_MUL) begin
                            ctrl_q <= 2'b01;
                            iter_q <= IT_MUL;
                            cnt_q  <= CNT_W'(DATA_W);
                        end else if (is_shift) begin
                            ctrl_q <= 2'b10;
                            iter_q <= (op == OP_SHL) ? IT_SHL : IT_SHR;
                            cnt_q  <= CNT_W'(shamt);
                        end else begin
                            ctrl_q <= is_illegal ? 2'b11 : 2'b00;
                        end
                        state_q <= fin_load ? S_DONE : S_EXEC;
                    end
                end
                S_EXEC: begin
                    acc_q    <= step_acc;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q - CNT_W'(1);
                    if (fin_load) state_q <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign alu_ctrl  = ctrl_q;
    assign illegal   = illegal_q;

`ifdef ALU_FLAGS_EN
    logic fin_c;
    logic flag_z_q;
    logic flag_n_q;
    logic flag_c_q;

    // ADD carry-out is recovered from the wrapped sum being smaller than an operand.
    always_comb begin
        fin_c = 1'b0;
        if (state_q == S_EXEC) begin
            if (iter_q == IT_SHL)      fin_c = acc_q[DATA_W-1];
            else if (iter_q == IT_SHR) fin_c = acc_q[0];
        end else if (op == OP_ADD) begin
            fin_c = (fin_res < a);
        end else if (op == OP_SUB) begin
            fin_c = (a < b);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_z_q <= 1'b0;
            flag_n_q <= 1'b0;
            flag_c_q <= 1'b0;
        end else if (fin_load) begin
            flag_z_q <= (fin_res == '0);
            flag_n_q <= fin_res[DATA_W-1];
            flag_c_q <= fin_c;
        end
    end

    assign flag_z = flag_z_q;
    assign flag_n = flag_n_q;
    assign flag_c = flag_c_q;
`endif

endmodule
